// File: rtl/mem_access_unit.sv
// Bridges the single-cycle core's load/store intent onto a req/ack data bus.
// The core is stalled for the whole access, and bad accesses are aborted with a fault code.
module mem_access_unit #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output logic [31:0] read_data,
    output logic        stall,
    output logic        fault,
    output logic [1:0]  fault_code,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    input  logic        bus_err
);

    // state | meaning
    // IDLE  | waiting for mem_read/mem_write; checks alignment and conflicts
    // REQ   | bus_req held until ack, error or timeout
    // DONE  | one unstalled cycle so the core retires the instruction
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    localparam logic [1:0] CODE_MISALIGN = 2'd0;
    localparam logic [1:0] CODE_CONFLICT = 2'd1;
    localparam logic [1:0] CODE_BUS_ERR  = 2'd2;
    localparam logic [1:0] CODE_TIMEOUT  = 2'd3;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic             access;
    logic             accept;
    logic             timeout_hit;
    logic             fault_nx;
    logic [1:0]       code_nx;

    assign access      = mem_read | mem_write;
    assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));
    assign bus_req     = (state == REQ);
    assign stall       = (state == REQ) | ((state == IDLE) & access);

    always_comb begin
        state_nx = state;
        fault_nx = 1'b0;
        code_nx  = fault_code;
        accept   = 1'b0;
        case (state)
            IDLE: begin
                if (access) begin
                    // Misalignment is reported ahead of a read/write conflict.
                    if (a[1:0] != 2'b00) begin
                        state_nx = DONE;
                        fault_nx = 1'b1;
                        code_nx  = CODE_MISALIGN;
                    end else if (mem_read & mem_write) begin
                        state_nx = DONE;
                        fault_nx = 1'b1;
                        code_nx  = CODE_CONFLICT;
                    end else begin
                        accept   = 1'b1;
                        state_nx = REQ;
                    end
                end
            end
            REQ: begin
                if (bus_err) begin
                    state_nx = DONE;
                    fault_nx = 1'b1;
                    code_nx  = CODE_BUS_ERR;
                end else if (bus_ack) begin
                    state_nx = DONE;
                end else if (timeout_hit) begin
                    state_nx = DONE;
                    fault_nx = 1'b1;
                    code_nx  = CODE_TIMEOUT;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            fault      <= 1'b0;
            fault_code <= 2'd0;
            bus_we     <= 1'b0;
            bus_addr   <= 32'd0;
            bus_wdata  <= 32'd0;
            read_data  <= 32'd0;
        end else begin
            state      <= state_nx;
            fault      <= fault_nx;
            fault_code <= code_nx;
            if (accept) begin
                bus_addr  <= a;
                bus_wdata <= wd;
                bus_we    <= mem_write;
                cnt       <= '0;
            end else if (state == REQ) begin
                cnt <= cnt + 1'b1;
            end
            if ((state == REQ) && !bus_err && bus_ack && !bus_we) begin
                read_data <= bus_rdata;
            end
        end
    end

endmodule
